// File: rtl/bird_column_ctrl.sv
// Bird column controller: tick divider, flap edge capture, IDLE/PLAY/DEAD game FSM.
// Optional macro BIRD_BLINK_EN blinks the bird LED while DEAD.
module bird_column_ctrl #(
    parameter int unsigned ROWS      = 8,
    parameter int unsigned TICK_DIV  = 1792,
    parameter int unsigned FLAP_ROWS = 2,
    parameter int unsigned START_ROW = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flap,
    input  logic [ROWS-1:0] pipeMask,
    output logic [ROWS-1:0] birdRow,
    output logic            dead,
    output logic            tick
);

    localparam int unsigned PW = $clog2(ROWS);
    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [PW-1:0]   pos, pos_n;
    logic [CW-1:0]   cnt;
    logic            flap_q;
    logic            pending;
    logic            rise;
    logic            pend_eff;
    logic [PW:0]     flap_sum;

    assign rise     = flap & ~flap_q;
    assign pend_eff = pending | rise;
    assign flap_sum = {1'b0, pos} + (PW+1)'(FLAP_ROWS);

    // Tick divider and flap edge/pending capture; a tick consumes any pending flap.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt     <= '0;
            flap_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            cnt     <= tick ? '0 : cnt + CW'(1);
            flap_q  <= flap;
            pending <= tick ? 1'b0 : pend_eff;
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            pos   <= PW'(START_ROW);
        end else begin
            state <= state_n;
            pos   <= pos_n;
        end
    end

    // Next-state: pipe collision beats any same-cycle tick move
    always_comb begin
        state_n = state;
        pos_n   = pos;
        case (state)
            IDLE: begin
                if (tick && pend_eff)
                    state_n = PLAY;
            end
            PLAY: begin
                if (pipeMask[pos]) begin
                    state_n = DEAD;
                end else if (tick) begin
                    if (pend_eff)
                        pos_n = (flap_sum > (PW+1)'(ROWS-1)) ? PW'(ROWS-1) : flap_sum[PW-1:0];
                    else if (pos == '0)
                        state_n = DEAD;
                    else
                        pos_n = pos - PW'(1);
                end
            end
            DEAD: begin
                if (tick && pend_eff) begin
                    state_n = IDLE;
                    pos_n   = PW'(START_ROW);
                end
            end
            default: begin
                state_n = IDLE;
                pos_n   = PW'(START_ROW);
            end
        endcase
    end

`ifdef BIRD_BLINK_EN
    logic blink_q;

    // Blink phase restarts dark-on-next-tick each time DEAD is entered
    always_ff @(posedge clock) begin
        if (reset || state != DEAD)
            blink_q <= 1'b0;
        else if (tick)
            blink_q <= ~blink_q;
    end
`endif

    // Outputs decoded from registered state, position and counter
    always_comb begin
        tick    = (cnt == CW'(TICK_DIV - 1));
        dead    = (state == DEAD);
        birdRow = ROWS'(1) << pos;
`ifdef BIRD_BLINK_EN
        if (dead && blink_q)
            birdRow = '0;
`endif
    end

endmodule

// File: tb/tb_bird_column_ctrl.sv
// Randomized bench for bird_column_ctrl against a tick-level game model.
module tb_bird_column_ctrl;

    localparam int ROWS      = 8;
    localparam int TICK_DIV  = 4;
    localparam int FLAP_ROWS = 2;
    localparam int START_ROW = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            flap  = 1'b0;
    logic [ROWS-1:0] pipeMask = '0;
    logic [ROWS-1:0] birdRow;
    logic            dead;
    logic            tick;

    bird_column_ctrl #(
        .ROWS(ROWS), .TICK_DIV(TICK_DIV), .FLAP_ROWS(FLAP_ROWS), .START_ROW(START_ROW)
    ) dut (
        .clock(clock), .reset(reset), .flap(flap), .pipeMask(pipeMask),
        .birdRow(birdRow), .dead(dead), .tick(tick)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Model: game phase 0=idle 1=play 2=dead, bird height, clocks since last tick
    int m_phase, m_pos, m_clk, m_dead_ticks;
    bit m_flap_armed, m_last_flap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int exp_row();
`ifdef BIRD_BLINK_EN
        if (m_phase == 2 && (m_dead_ticks % 2) == 1) return 0;
`endif
        return 1 << m_pos;
    endfunction

    task automatic model_clock();
        bit is_tick, flapped;
        if (reset) begin
            m_phase = 0; m_pos = START_ROW; m_clk = 0; m_dead_ticks = 0;
            m_flap_armed = 0; m_last_flap = 0;
            return;
        end
        is_tick = (m_clk == TICK_DIV - 1);
        flapped = m_flap_armed || (flap && !m_last_flap);
        if (m_phase == 2 && is_tick) m_dead_ticks++;
        if (m_phase == 1 && pipeMask[m_pos]) begin
            m_phase = 2;
        end else if (is_tick) begin
            if (m_phase == 0 && flapped) m_phase = 1;
            else if (m_phase == 1) begin
                if (flapped) m_pos = (m_pos + FLAP_ROWS > ROWS - 1) ? ROWS - 1 : m_pos + FLAP_ROWS;
                else if (m_pos == 0) m_phase = 2;
                else m_pos = m_pos - 1;
            end else if (m_phase == 2 && flapped) begin
                m_phase = 0; m_pos = START_ROW;
            end
        end
        if (m_phase != 2) m_dead_ticks = 0;
        m_flap_armed = is_tick ? 1'b0 : flapped;
        m_last_flap  = flap;
        m_clk        = (m_clk + 1) % TICK_DIV;
    endtask

    task automatic step();
        @(posedge clock);
        model_clock();
        #1;
        check("tick", 32'(tick), 32'(m_clk == TICK_DIV - 1));
        check("dead", 32'(dead), 32'(m_phase == 2));
        check("birdRow", 32'(birdRow), 32'(exp_row()));
    endtask

    int rate;

    initial begin
        m_phase = 0; m_pos = START_ROW; m_clk = 0; m_dead_ticks = 0;
        m_flap_armed = 0; m_last_flap = 0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        // Idle after reset: ticks every fourth clock, bird parked at START_ROW
        for (int i = 0; i < 12; i++) step();
        check("idle_row", 32'(birdRow), 32'h10);

        // Start a game then fall to the ground
        flap = 1'b1; step(); flap = 1'b0;
        for (int i = 0; i < 30; i++) step();

        for (int cyc = 0; cyc < 6000; cyc++) begin
            case ((cyc / 256) % 3)
                0: rate = 2;
                1: rate = 12;
                default: rate = 48;
            endcase
            if ($urandom_range(rate - 1) == 0) flap = ~flap;
            pipeMask = '0;
            if ($urandom_range(29) == 0) pipeMask[$urandom_range(ROWS - 1)] = 1'b1;
            reset = ($urandom_range(599) == 0);
            step();
        end
        reset = 1'b0;
        pipeMask = '0;
        flap = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
